// File: rtl/alu_mdu_seq_if.sv
// Start/busy/done handshake bundle between the execute stage and alu_mdu_seq.
// The master drives requests and operands; the slave (the MDU) returns status and result.
interface alu_mdu_seq_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] srca;
  logic [XLEN-1:0] srcb;
  logic            busy;
  logic            done;
  logic            illegal;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, srca, srcb,
    input  busy, done, illegal, result
  );

  modport slave (
    input  start, funct3, srca, srcb,
    output busy, done, illegal, result
  );
endinterface

// File: rtl/alu_mdu_seq.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, fixed XLEN+2 latency.
// Define MDU_DIV_EN to build the divider; without it divide ops complete with illegal=1.
module alu_mdu_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic         clk,
  input  logic         reset,
  alu_mdu_seq_if.slave bus
);

  localparam int unsigned CW = $clog2(XLEN + 1);
  localparam int unsigned PW = 2 * XLEN;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]      state, state_nxt;
  logic [CW-1:0]   count;
  logic [2:0]      op;
  logic [XLEN-1:0] opd;
  logic [PW-1:0]   acc;
  logic            neg_hi;
  logic            accept_c;

  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [XLEN:0]   mul_sum;
  logic [PW-1:0]   mul_acc;
  logic [PW-1:0]   prod;
  logic [XLEN-1:0] fix_res;

`ifdef MDU_DIV_EN
  logic            neg_lo, div_zero, div_ovf;
  logic [XLEN:0]   div_tmp, div_diff;
  logic [PW-1:0]   div_acc;
  logic [XLEN-1:0] quo, rem;
`endif

  assign accept_c = (state == IDLE) && bus.start;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = CALC;
      CALC:    if (count == CW'(1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand signedness and magnitude at accept
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (bus.funct3)
      3'b001: begin a_sgn = 1'b1; b_sgn = 1'b1; end
      3'b010: a_sgn = 1'b1;
`ifdef MDU_DIV_EN
      3'b100, 3'b110: begin a_sgn = 1'b1; b_sgn = 1'b1; end
`endif
      default: ;
    endcase
    a_neg = a_sgn & bus.srca[XLEN-1];
    b_neg = b_sgn & bus.srcb[XLEN-1];
    a_abs = a_neg ? (~bus.srca + XLEN'(1)) : bus.srca;
    b_abs = b_neg ? (~bus.srcb + XLEN'(1)) : bus.srcb;
  end

  // Shift-add step: multiplier sits in the low half and shifts out as the product shifts in
  always_comb begin
    mul_sum = {1'b0, acc[PW-1:XLEN]} + {1'b0, (acc[0] ? opd : '0)};
    mul_acc = {mul_sum, acc[XLEN-1:1]};
  end

`ifdef MDU_DIV_EN
  // Restoring step: remainder in the high half, dividend/quotient in the low half
  always_comb begin
    div_tmp  = {acc[PW-1:XLEN], acc[XLEN-1]};
    div_diff = div_tmp - {1'b0, opd};
    if (!div_diff[XLEN]) div_acc = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else                 div_acc = {div_tmp[XLEN-1:0], acc[XLEN-2:0], 1'b0};
  end
`endif

  // Sign correction, half/quotient selection and special-case overrides
  always_comb begin
    prod    = neg_hi ? (~acc + PW'(1)) : acc;
    fix_res = '0;
`ifdef MDU_DIV_EN
    quo = neg_hi ? (~acc[XLEN-1:0] + XLEN'(1)) : acc[XLEN-1:0];
    rem = neg_lo ? (~acc[PW-1:XLEN] + XLEN'(1)) : acc[PW-1:XLEN];
`endif
    case (op)
      3'b000:                 fix_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod[PW-1:XLEN];
`ifdef MDU_DIV_EN
      3'b100: fix_res = div_zero ? '1 : (div_ovf ? {1'b1, {(XLEN-1){1'b0}}} : quo);
      3'b101: fix_res = div_zero ? '1 : quo;
      3'b110: fix_res = div_ovf ? '0 : rem;
      3'b111: fix_res = rem;
`endif
      default: fix_res = '0;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= '0;
      op          <= '0;
      opd         <= '0;
      acc         <= '0;
      neg_hi      <= 1'b0;
`ifdef MDU_DIV_EN
      neg_lo      <= 1'b0;
      div_zero    <= 1'b0;
      div_ovf     <= 1'b0;
`endif
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.illegal <= 1'b0;
      bus.result  <= '0;
    end else begin
      bus.busy    <= (state_nxt != IDLE);
      bus.done    <= (state_nxt == DONE);
      bus.illegal <= 1'b0;
      if (accept_c) begin
        op     <= bus.funct3;
        count  <= CW'(XLEN);
        neg_hi <= a_neg ^ b_neg;
`ifdef MDU_DIV_EN
        neg_lo   <= a_neg;
        div_zero <= (bus.srcb == '0);
        div_ovf  <= (bus.srca == {1'b1, {(XLEN-1){1'b0}}}) && (bus.srcb == '1);
        if (bus.funct3[2]) begin
          opd <= b_abs;
          acc <= {{XLEN{1'b0}}, a_abs};
        end else begin
          opd <= a_abs;
          acc <= {{XLEN{1'b0}}, b_abs};
        end
`else
        opd <= a_abs;
        acc <= {{XLEN{1'b0}}, b_abs};
`endif
      end else if (state == CALC) begin
        count <= count - CW'(1);
`ifdef MDU_DIV_EN
        acc <= op[2] ? div_acc : mul_acc;
`else
        acc <= mul_acc;
`endif
      end else if (state == FIX) begin
        bus.result <= fix_res;
`ifndef MDU_DIV_EN
        bus.illegal <= op[2];
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Scoreboard bench for alu_mdu_seq at XLEN=32; expectations follow the MDU_DIV_EN build setting.
module tb_alu_mdu_seq;

  localparam int unsigned XLEN = 32;
  localparam int unsigned LAT  = XLEN + 2;
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [32:0] sb[$];

  alu_mdu_seq_if #(.XLEN(XLEN)) bus ();

  alu_mdu_seq #(.XLEN(XLEN)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference: returns {illegal, result}
  function automatic logic [32:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    logic        ill;
    logic        ovf;
    r   = '0;
    ill = 1'b0;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
      3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); r = p[63:32]; end
      3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); r = p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      default: begin
        if (!DIV_EN) begin
          r = '0; ill = 1'b1;
        end else begin
          case (f)
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default: r = (b == 0) ? a : a % b;
          endcase
        end
      end
    endcase
    return {ill, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from an idle cycle, then check latency and scoreboard result
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic ei);
    int lat;
    logic [32:0] exp;
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.srca   = a;
    bus.srcb   = b;
    sb.push_back({ei, er});
    lat = 0;
    do begin
      tick();
      lat++;
      bus.start  = 1'b0;
      bus.funct3 = ~f;
      bus.srca   = ~a;
      bus.srcb   = ~b;
    end while (!bus.done && lat < 100);
    exp = sb.pop_front();
    checks++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, LAT);
    end
    checks++;
    if (bus.result !== exp[31:0]) begin
      errors++;
      $display("FAIL %s result: got %h expected %h", name, bus.result, exp[31:0]);
    end
    checks++;
    if (bus.illegal !== exp[32]) begin
      errors++;
      $display("FAIL %s illegal: got %b expected %b", name, bus.illegal, exp[32]);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_after: got busy=%b done=%b expected 0 0", name, bus.busy, bus.done);
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.funct3 = '0;
    bus.srca   = '0;
    bus.srcb   = '0;
    repeat (3) tick();
    checks++;
    if ({bus.busy, bus.done, bus.illegal} !== 3'b000 || bus.result !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b illegal=%b result=%h expected all 0",
               bus.busy, bus.done, bus.illegal, bus.result);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_mul();
    run_op("mul",    3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    run_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    run_op("mul3x4", 3'd0, 32'd3,        32'd4,         32'd12,        1'b0);
  endtask

  task automatic test_div();
    run_op("div",  3'd4, 32'hFFFF_FFF9, 32'd2, DIV_EN ? 32'hFFFF_FFFD : 32'h0, !DIV_EN);
    run_op("rem",  3'd6, 32'hFFFF_FFF9, 32'd2, DIV_EN ? 32'hFFFF_FFFF : 32'h0, !DIV_EN);
    run_op("divu", 3'd5, 32'd100,       32'd7, DIV_EN ? 32'd14 : 32'h0,         !DIV_EN);
    run_op("remu", 3'd7, 32'd100,       32'd7, DIV_EN ? 32'd2 : 32'h0,          !DIV_EN);
  endtask

  task automatic test_div_special();
    run_op("divu_z", 3'd5, 32'd5,         32'd0,         DIV_EN ? 32'hFFFF_FFFF : 32'h0, !DIV_EN);
    run_op("remu_z", 3'd7, 32'd5,         32'd0,         DIV_EN ? 32'd5 : 32'h0,         !DIV_EN);
    run_op("div_z",  3'd4, 32'hFFFF_FFF9, 32'd0,         DIV_EN ? 32'hFFFF_FFFF : 32'h0, !DIV_EN);
    run_op("rem_z",  3'd6, 32'hFFFF_FFF9, 32'd0,         DIV_EN ? 32'hFFFF_FFF9 : 32'h0, !DIV_EN);
    run_op("div_ov", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, DIV_EN ? 32'h8000_0000 : 32'h0, !DIV_EN);
    run_op("rem_ov", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,                          !DIV_EN);
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] a, b;
    logic [32:0] e;
    for (int i = 0; i < 8; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom();
      b = (i == 3) ? 32'h0 : $urandom();
      e = model(f, a, b);
      run_op("random", f, a, b, e[31:0], e[32]);
    end
  endtask

  // start held high with fresh operands every cycle: accepts only at 0, 35, 70
  task automatic test_back_to_back();
    logic [32:0] exp;
    logic        exp_done;
    for (int c = 0; c <= 104; c++) begin
      exp_done = ((c % (LAT + 1)) == LAT);
      checks++;
      if (bus.done !== exp_done) begin
        errors++;
        $display("FAIL b2b_done cycle %0d: got %b expected %b", c, bus.done, exp_done);
      end
      if (exp_done && bus.done === 1'b1) begin
        exp = sb.pop_front();
        checks++;
        if ({bus.illegal, bus.result} !== exp) begin
          errors++;
          $display("FAIL b2b_result cycle %0d: got %b/%h expected %b/%h",
                   c, bus.illegal, bus.result, exp[32], exp[31:0]);
        end
      end
      bus.start  = (c < 104);
      bus.funct3 = 3'($urandom_range(0, 7));
      bus.srca   = $urandom();
      bus.srcb   = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 9)) : $urandom();
      if (c % (LAT + 1) == 0 && c < 104) sb.push_back(model(bus.funct3, bus.srca, bus.srcb));
      tick();
    end
    bus.start = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    bit seen;
    run_op("pre_mul", 3'd0, 32'd5, 32'd5, 32'd25, 1'b0);
    bus.start  = 1'b1;
    bus.funct3 = 3'd4;
    bus.srca   = 32'd1000;
    bus.srcb   = 32'd7;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.result !== '0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b result=%h expected 0 0", bus.busy, bus.result);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_mid_no_done: got done=1 expected none");
    end
    bus.start = 1'b1;
    reset     = 1'b1;
    tick();
    bus.start = 1'b0;
    reset     = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_vs_start: got busy=%b expected 0", bus.busy);
    end
    run_op("post_mul", 3'd0, 32'd3, 32'd4, 32'd12, 1'b0);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_special();
    test_random();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mdu_seq.md
# alu_mdu_seq

Parametrised multi-cycle multiply/divide unit for the RV32M extension. It sits beside the main ALU in the execute stage and decodes `funct3` directly, as the ALU decoder does for base operations. Each operation runs iteratively at one bit per cycle, with a fixed latency and a start/busy/done handshake. The controller FSM holds in its execute state until `done` is seen.

## Interface

Parameters:
- `XLEN`, default 32: operand and result width; legal values are 8..64.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request an operation; sampled only when `busy`=0.
- `funct3`, input, 3: M-extension operation select; sampled at accept.
- `srca`, input, XLEN: rs1 operand; sampled at accept.
- `srcb`, input, XLEN: rs2 operand; sampled at accept.
- `busy`, output, 1: operation in flight; high from the cycle after accept through the `done` cycle.
- `done`, output, 1: one-cycle pulse; `result` is valid in that cycle.
- `result`, output, XLEN: registered result; held until the next accept.
- `illegal`, output, 1: pulses together with `done` when a divide is requested in a build without divide support.

## Operation

funct3 decode:
- 000 MUL: low half of the product.
- 001 MULH: high half, signed×signed.
- 010 MULHSU: high half, signed×unsigned.
- 011 MULHU: high half, unsigned×unsigned.
- 100 DIV: signed quotient.
- 101 DIVU: unsigned quotient.
- 110 REM: signed remainder.
- 111 REMU: unsigned remainder.

FSM states:
- IDLE: leave when `start`=1. On that edge:
  - latch the absolute values of signed operands;
  - record the result sign and the op;
  - set `count` = XLEN;
  - go to CALC.
- CALC: one shift-add step (multiply) or one restoring shift-subtract step (divide) per cycle.
  - `count` decrements each cycle.
  - Go to FIX when `count` reaches 1.
  - CALC lasts exactly XLEN cycles.
- FIX:
  - Apply sign correction: two's-complement negate over the 2·XLEN product, or separately over quotient and remainder.
  - Select the hi/lo half or quotient/remainder.
  - Apply the special-case overrides.
  - Write `result`; go to DONE.
- DONE: `done`=1; go to IDLE.

Arithmetic rules:
- The product accumulator is 2·XLEN bits.
- The remainder takes the sign of the dividend.
- The quotient is truncated toward zero.
- Divide by zero:
  - DIV and DIVU return all ones.
  - REM and REMU return `srca` unchanged.
- Signed overflow (DIV/REM with `srca`=100…0 and `srcb`=all ones):
  - DIV returns 100…0.
  - REM returns 0.
- Special cases use the same latency as normal operations; they are overrides applied in FIX.

Boundary conditions:
- `start` while `busy`=1 is ignored. It is not queued and there is no error indication.
- `start` in the DONE cycle is ignored. The earliest re-accept is the cycle after `done`.
- Changes to `srca`, `srcb` or `funct3` after accept have no effect.
- `reset` asserted in any state:
  - next state is IDLE;
  - `busy`, `done`, `illegal` and `result` go to 0;
  - the in-flight operation is discarded and no `done` is produced.
- `reset` and `start` together: reset wins and nothing is accepted.

## Timing

- Reset values: `busy`=0, `done`=0, `illegal`=0, `result`=0, state IDLE.
- Cycle numbering: accept edge at the end of cycle 0 (cycle 0 is the cycle in which `start` is high and `busy`=0).
  - CALC: cycles 1..XLEN.
  - FIX: cycle XLEN+1.
  - DONE: cycle XLEN+2.
- Latency from start to `done` is XLEN+2 cycles (34 for XLEN=32). This holds for every op and every operand value.
- `busy`=1 in cycles 1..XLEN+2.
- Throughput is one operation per XLEN+3 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration

- Macro: `MDU_DIV_EN`.
- Defined:
  - The divider datapath is built.
  - All eight funct3 codes are supported.
  - `illegal` is tied to 0.
- Undefined:
  - No divider logic is built; the multiplier only.
  - funct3[2]=1 is still accepted, and the handshake and latency are unchanged (XLEN+2).
  - `result`=0 and `illegal`=1 in the `done` cycle.
  - Multiply behaviour is identical to the defined build.

## Test plan

XLEN=32 for all scenarios.

- MUL `srca`=7, `srcb`=0xFFFFFFFD → `done` exactly 34 cycles after accept, `result`=0xFFFFFFEB; MULH 0x80000000×0x80000000 → 0x40000000; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Divide by zero: DIVU 5/0 → 0xFFFFFFFF, REMU 5/0 → 5, DIV 0xFFFFFFF9/0 → 0xFFFFFFFF. Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM same operands → 0. All with latency 34.
- Hold `start`=1 continuously with changing operands → accepts occur only in cycles 0, 35, 70; each result matches the operands present at its accept cycle.
- Assert `reset` in cycle 10 of a DIV → `busy`=0 and `result`=0 in cycle 11; no `done` appears; a fresh MUL 3×4 started afterwards returns 12 in 34 cycles.
- Build without `MDU_DIV_EN`: DIVU 100/7 → `done` at cycle 34 with `result`=0 and `illegal`=1; MUL 3×4 → 12 with `illegal`=0.
